// File: rtl/d_ff.sv
// d_ff: WIDTH-bit rising-edge D register with async active-high reset and inverted output
module d_ff #(
  parameter int unsigned WIDTH = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q_next,
  output logic [WIDTH-1:0] q_n
);
  logic [WIDTH-1:0] q_d, q_q;
  always_comb begin
    q_d = d;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= RESET_VALUE;
    else q_q <= q_d;
  end
  assign q_next = q_q;
  assign q_n = ~q_q;
endmodule

// File: tb/tb_d_ff.sv
// tb_d_ff: directed timeline checks of a 1-bit and an 8-bit d_ff sharing one clock
`timescale 1ns/1ps
module tb_d_ff;
  logic clk, rst, rst8;
  logic d, q, qn;
  logic [7:0] d8, q8, qn8;
  int total = 0;
  int bad = 0;

  d_ff u_d1 (.clk(clk), .rst(rst), .d(d), .q_next(q), .q_n(qn));
  d_ff #(.WIDTH(8), .RESET_VALUE(8'hA5)) u_d8 (.clk(clk), .rst(rst8), .d(d8), .q_next(q8), .q_n(qn8));

  // rising edges at 0, 4, 8, ... ns
  initial begin
    clk = 1'b0;
    #0 clk = 1'b1;
    forever #2 clk = ~clk;
  end

  task automatic at_t(input realtime t);
    #(t - $realtime);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; d = 1'b1; rst8 = 1'b1; d8 = 8'h3C;
    at_t(1);    rst = 1'b1;
    at_t(2);    chk("rst_async_q", q, 0); chk("rst_async_qn", qn, 1);
    at_t(5);    chk("rst_hold_e4", q, 0); d = 1'b0;
                chk("w8_rst_q", q8, 8'hA5); chk("w8_rst_qn", qn8, 8'h5A); d8 = 8'h55;
    at_t(9);    chk("rst_hold_e8_q", q, 0); chk("rst_hold_e8_qn", qn, 1); rst = 1'b0;
    at_t(10);   chk("post_rel_t10", q, 0); d = 1'b1;
    at_t(13);   chk("edge12_q", q, 1); d = 1'b0;
    at_t(13.5); chk("hold_t13_5", q, 1);
    at_t(14);   d = 1'b1; chk("hold_t14", q, 1);
    at_t(15);   chk("hold_t15", q, 1); d = 1'b0; d8 = 8'hAA;
    at_t(16.5); chk("edge16_q", q, 0);
    at_t(20);   chk("hold_t20", q, 0); d = 1'b1;
    at_t(22);   chk("w8_rst_toggle", q8, 8'hA5);
    at_t(25);   chk("edge24_q", q, 1); chk("edge24_qn", qn, 0);
    at_t(25.5); rst = 1'b1;
    at_t(25.6); chk("mid_rst_q", q, 0); chk("mid_rst_qn", qn, 1);
    at_t(26);   rst = 1'b0;
    at_t(27);   chk("no_edge_after_rel", q, 0);
    at_t(29);   chk("edge28_q", q, 1); rst = 1'b1;
    at_t(30);   d = 1'b0;
    at_t(31);   chk("rst_held_t31", q, 0);
    at_t(33);   d = 1'b1;
    at_t(37);   chk("rst_held_t37", q, 0); rst = 1'b0;
    at_t(41);   chk("edge40_q", q, 1);
    at_t(44);   rst = 1'b1;
    at_t(44.5); chk("rst_wins_edge", q, 0);
    at_t(45);   chk("w8_rst_end", q8, 8'hA5); rst8 = 1'b0; d8 = 8'h3C;
    at_t(46);   chk("w8_no_edge", q8, 8'hA5);
    at_t(49);   chk("w8_load_q", q8, 8'h3C); chk("w8_load_qn", qn8, 8'hC3);
    at_t(50);   d8 = 8'hFF;
    at_t(53);   chk("w8_ff_q", q8, 8'hFF); chk("w8_ff_qn", qn8, 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
